// File: rtl/lg_prefix_unit.sv
// Prefix-reduction gate array (AND/OR/XOR/NAND) with registered output.
// Define LG_SWEEP_EN to compile in the exhaustive sweep engine (FSM, pattern counter, signature count).

module lg_prefix_cell #(
   parameter int W = 2
) (
   input  logic [W-1:0] a,
   input  logic [1:0]   op,
   output logic         y
);
   // NAND is the inverted AND of the whole prefix, not a chained NAND.
   always_comb begin
      y = 1'b0;
      case (op)
         2'b00:   y = &a;
         2'b01:   y = |a;
         2'b10:   y = ^a;
         default: y = ~&a;
      endcase
   end
endmodule

module lg_prefix_unit #(
   parameter int N = 4
) (
   input  logic         CLK,
   input  logic         RST,
   input  logic         IN_VALID,
   input  logic [N-1:0] A,
   input  logic [1:0]   OP,
   input  logic         START,
   output logic [N-2:0] Y,
   output logic         OUT_VALID,
   output logic         BUSY,
   output logic         DONE,
   output logic [N:0]   COUNT
);
   logic [N-1:0] src;
   logic [1:0]   op_sel;
   logic [N-2:0] f;

   // One shared gate array; the source vector is A in direct mode, P while sweeping.
   generate
      for (genvar k = 1; k < N; k++) begin : g_cell
         lg_prefix_cell #(.W(k + 1)) u_cell (
            .a  (src[k:0]),
            .op (op_sel),
            .y  (f[k-1])
         );
      end
   endgenerate

`ifdef LG_SWEEP_EN
   typedef enum logic [1:0] {S_IDLE, S_SWEEP, S_DONE} state_t;

   localparam logic [N-1:0] P_LAST = '1;

   state_t       state;
   logic [N-1:0] p;
   logic [1:0]   op_lat;

   assign src    = (state == S_SWEEP) ? p      : A;
   assign op_sel = (state == S_SWEEP) ? op_lat : OP;

   always_ff @(posedge CLK) begin
      if (RST) begin
         state     <= S_IDLE;
         p         <= '0;
         op_lat    <= 2'b00;
         Y         <= '0;
         OUT_VALID <= 1'b0;
         BUSY      <= 1'b0;
         DONE      <= 1'b0;
         COUNT     <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (START) begin
                  // START beats a simultaneous direct vector.
                  state     <= S_SWEEP;
                  op_lat    <= OP;
                  p         <= '0;
                  COUNT     <= '0;
                  BUSY      <= 1'b1;
                  OUT_VALID <= 1'b0;
               end else if (IN_VALID) begin
                  Y         <= f;
                  OUT_VALID <= 1'b1;
               end else begin
                  OUT_VALID <= 1'b0;
               end
            end
            S_SWEEP: begin
               Y         <= f;
               OUT_VALID <= 1'b1;
               COUNT     <= COUNT + {{N{1'b0}}, f[N-2]};
               if (p == P_LAST) begin
                  state <= S_DONE;
                  DONE  <= 1'b1;
               end else begin
                  p <= p + {{(N-1){1'b0}}, 1'b1};
               end
            end
            S_DONE: begin
               state     <= S_IDLE;
               DONE      <= 1'b0;
               BUSY      <= 1'b0;
               OUT_VALID <= 1'b0;
            end
            default: state <= S_IDLE;
         endcase
      end
   end
`else
   logic unused_start;

   assign unused_start = START;
   assign src          = A;
   assign op_sel       = OP;
   assign BUSY         = 1'b0;
   assign DONE         = 1'b0;
   assign COUNT        = '0;

   always_ff @(posedge CLK) begin
      if (RST) begin
         Y         <= '0;
         OUT_VALID <= 1'b0;
      end else if (IN_VALID) begin
         Y         <= f;
         OUT_VALID <= 1'b1;
      end else begin
         OUT_VALID <= 1'b0;
      end
   end
`endif
endmodule

// File: tb/tb_lg_prefix_unit.sv
// Directed bench for lg_prefix_unit (N=4); sweep scenarios only when LG_SWEEP_EN is defined.

module tb_lg_prefix_unit;
   localparam int N = 4;

   logic         CLK = 1'b0;
   logic         RST;
   logic         IN_VALID;
   logic [N-1:0] A;
   logic [1:0]   OP;
   logic         START;
   logic [N-2:0] Y;
   logic         OUT_VALID;
   logic         BUSY;
   logic         DONE;
   logic [N:0]   COUNT;

   int checks   = 0;
   int failures = 0;

   lg_prefix_unit #(.N(N)) dut (
      .CLK       (CLK),
      .RST       (RST),
      .IN_VALID  (IN_VALID),
      .A         (A),
      .OP        (OP),
      .START     (START),
      .Y         (Y),
      .OUT_VALID (OUT_VALID),
      .BUSY      (BUSY),
      .DONE      (DONE),
      .COUNT     (COUNT)
   );

   always #5 CLK = ~CLK;

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   // Reference prefix model used to score sweep outputs.
   function automatic logic [N-2:0] ref_prefix(input logic [N-1:0] a, input logic [1:0] op);
      logic [N-2:0] r;
      logic acc_and, acc_or, acc_xor;
      r = '0;
      acc_and = a[0]; acc_or = a[0]; acc_xor = a[0];
      for (int k = 1; k < N; k++) begin
         acc_and = acc_and & a[k];
         acc_or  = acc_or  | a[k];
         acc_xor = acc_xor ^ a[k];
         case (op)
            2'b00:   r[k-1] = acc_and;
            2'b01:   r[k-1] = acc_or;
            2'b10:   r[k-1] = acc_xor;
            default: r[k-1] = ~acc_and;
         endcase
      end
      return r;
   endfunction

   task automatic test_reset();
      RST = 1'b1;
      for (int c = 0; c < 2; c++) begin
         IN_VALID = 1'($urandom_range(0, 1));
         A        = N'($urandom);
         OP       = 2'($urandom);
         START    = 1'($urandom_range(0, 1));
         tick();
         checks++;
         if ({Y, OUT_VALID, BUSY, DONE, COUNT} !== '0) begin
            failures++;
            $display("FAIL reset cyc%0d: Y=%b OUT_VALID=%b BUSY=%b DONE=%b COUNT=%0d, want all 0",
                     c, Y, OUT_VALID, BUSY, DONE, COUNT);
         end
      end
      RST = 1'b0; IN_VALID = 1'b0; START = 1'b0; A = '0; OP = 2'b00;
      tick();
   endtask

   task automatic test_direct_and();
      logic [N-1:0] va [3] = '{4'b0011, 4'b0111, 4'b1111};
      logic [N-2:0] vy [3] = '{3'b001, 3'b011, 3'b111};
      OP = 2'b00;
      IN_VALID = 1'b1;
      for (int i = 0; i < 3; i++) begin
         A = va[i];
         tick();
         checks++;
         if (Y !== vy[i] || OUT_VALID !== 1'b1) begin
            failures++;
            $display("FAIL direct_and[%0d]: Y=%b OUT_VALID=%b, want Y=%b OUT_VALID=1",
                     i, Y, OUT_VALID, vy[i]);
         end
      end
      IN_VALID = 1'b0;
      A = 4'b0000;
      tick();
      checks++;
      if (Y !== 3'b111 || OUT_VALID !== 1'b0) begin
         failures++;
         $display("FAIL direct_hold: Y=%b OUT_VALID=%b, want Y=111 OUT_VALID=0", Y, OUT_VALID);
      end
   endtask

   task automatic test_direct_xor_nand();
      IN_VALID = 1'b1;
      OP = 2'b10; A = 4'b0101;
      tick();
      checks++;
      if (Y !== 3'b001 || OUT_VALID !== 1'b1) begin
         failures++;
         $display("FAIL direct_xor: Y=%b OUT_VALID=%b, want Y=001 OUT_VALID=1", Y, OUT_VALID);
      end
      OP = 2'b11; A = 4'b0011;
      tick();
      checks++;
      if (Y !== 3'b110 || OUT_VALID !== 1'b1) begin
         failures++;
         $display("FAIL direct_nand: Y=%b OUT_VALID=%b, want Y=110 OUT_VALID=1", Y, OUT_VALID);
      end
      OP = 2'b01; A = 4'b0100;
      tick();
      checks++;
      if (Y !== 3'b110 || OUT_VALID !== 1'b1) begin
         failures++;
         $display("FAIL direct_or: Y=%b OUT_VALID=%b, want Y=110 OUT_VALID=1", Y, OUT_VALID);
      end
      IN_VALID = 1'b0;
      tick();
   endtask

`ifdef LG_SWEEP_EN
   // collide=1 holds START/IN_VALID high (with a different OP) throughout the sweep.
   task automatic run_sweep(input logic [1:0] op, input int exp_count, input bit collide, input string name);
      int busy_n = 0, ov_n = 0, done_n = 0, y_err = 0;
      logic [N:0] cnt_done = '0;
      OP = op; START = 1'b1; IN_VALID = collide; A = 4'b1111;
      tick();
      checks++;
      if (BUSY !== 1'b1 || OUT_VALID !== 1'b0) begin
         failures++;
         $display("FAIL %s_start: BUSY=%b OUT_VALID=%b, want BUSY=1 OUT_VALID=0", name, BUSY, OUT_VALID);
      end
      START = collide; OP = collide ? ~op : op;
      for (int i = 0; i < 40; i++) begin
         if (BUSY) busy_n++;
         if (OUT_VALID) begin
            if (Y !== ref_prefix(N'(ov_n), op)) y_err++;
            ov_n++;
         end
         if (DONE) begin done_n++; cnt_done = COUNT; end
         if (!BUSY) break;
         tick();
      end
      START = 1'b0; IN_VALID = 1'b0;
      checks++;
      if (busy_n !== 17 || ov_n !== 16 || done_n !== 1) begin
         failures++;
         $display("FAIL %s_timing: busy=%0d valid=%0d done=%0d, want 17/16/1", name, busy_n, ov_n, done_n);
      end
      checks++;
      if (y_err !== 0) begin
         failures++;
         $display("FAIL %s_y: %0d wrong Y values, want 0", name, y_err);
      end
      checks++;
      if (cnt_done !== (N+1)'(exp_count)) begin
         failures++;
         $display("FAIL %s_count: COUNT=%0d, want %0d", name, cnt_done, exp_count);
      end
      tick();
      checks++;
      if (COUNT !== (N+1)'(exp_count) || BUSY !== 1'b0) begin
         failures++;
         $display("FAIL %s_hold: COUNT=%0d BUSY=%b, want %0d/0", name, COUNT, BUSY, exp_count);
      end
   endtask

   task automatic test_sweep();
      run_sweep(2'b01, 15, 1'b0, "sweep_or");
      run_sweep(2'b00, 1,  1'b0, "sweep_and");
      run_sweep(2'b10, 8,  1'b0, "sweep_xor");
      run_sweep(2'b11, 15, 1'b0, "sweep_nand");
   endtask

   task automatic test_collisions();
      run_sweep(2'b00, 1, 1'b1, "collide");
   endtask

   task automatic test_reset_mid_sweep();
      int done_n = 0, busy_n = 0;
      OP = 2'b01; START = 1'b1;
      tick();
      START = 1'b0;
      for (int i = 0; i < 4; i++) tick();
      RST = 1'b1;
      tick();
      RST = 1'b0;
      checks++;
      if ({Y, OUT_VALID, BUSY, DONE, COUNT} !== '0) begin
         failures++;
         $display("FAIL mid_reset: Y=%b OUT_VALID=%b BUSY=%b DONE=%b COUNT=%0d, want all 0",
                  Y, OUT_VALID, BUSY, DONE, COUNT);
      end
      for (int i = 0; i < 20; i++) begin
         tick();
         if (DONE) done_n++;
         if (BUSY) busy_n++;
      end
      checks++;
      if (done_n !== 0 || busy_n !== 0) begin
         failures++;
         $display("FAIL mid_reset_after: done=%0d busy=%0d, want 0/0", done_n, busy_n);
      end
   endtask
`else
   task automatic test_macro_off();
      int bad = 0;
      START = 1'b1; IN_VALID = 1'b0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (BUSY !== 1'b0 || DONE !== 1'b0 || COUNT !== '0) bad++;
      end
      checks++;
      if (bad !== 0) begin
         failures++;
         $display("FAIL macro_off_idle: %0d cycles with BUSY/DONE/COUNT nonzero, want 0", bad);
      end
      IN_VALID = 1'b1; OP = 2'b00; A = 4'b1111;
      tick();
      checks++;
      if (Y !== 3'b111 || OUT_VALID !== 1'b1 || BUSY !== 1'b0) begin
         failures++;
         $display("FAIL macro_off_direct: Y=%b OUT_VALID=%b BUSY=%b, want 111/1/0", Y, OUT_VALID, BUSY);
      end
      START = 1'b0; IN_VALID = 1'b0;
      tick();
   endtask
`endif

   initial begin
      RST = 1'b1; IN_VALID = 1'b0; A = '0; OP = 2'b00; START = 1'b0;
      test_reset();
      test_direct_and();
      test_direct_xor_nand();
`ifdef LG_SWEEP_EN
      test_sweep();
      test_collisions();
      test_reset_mid_sweep();
      test_direct_and();
`else
      test_macro_off();
      test_direct_and();
      test_direct_xor_nand();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
